// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the
// sequential multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } mdu_state_e;

  localparam int XLEN_MAX = 64;

  // Most-negative value at the widest legal width;
  // shifted down to XLEN where it is used.
  localparam logic [XLEN_MAX-1:0] MOST_NEG_MAX =
    {1'b1, {(XLEN_MAX-1){1'b0}}};

  // funct3[2] separates the divide group.
  function automatic logic op_is_div(mdu_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/response bundle between a
// requester (master) and the MDU (slave).
interface mdu_if #(
  parameter int XLEN = 32
);

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            div_zero;

  modport master (
    output start, op, src_a, src_b,
    input  busy, done, result, div_zero
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, done, result, div_zero
  );

endinterface

// File: rtl/mdu_step.sv
// mdu_step: one shift-add multiply bit or one
// restoring divide bit on the hi/lo register pair.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum;
  logic [XLEN+1:0] diff;
  logic            borrow;

  // Multiply: add multiplicand when lo[0] set,
  // then shift {carry,hi,lo} right by one.
  // Divide: shift dividend bit into remainder,
  // keep the trial difference if it did not borrow.
  always_comb begin
    sum    = {1'b0, hi_i} +
             (lo_i[0] ? {1'b0, b_i} : '0);
    diff   = {1'b0, hi_i, lo_i[XLEN-1]} -
             {2'b00, b_i};
    borrow = diff[XLEN+1];
    hi_o   = sum[XLEN:1];
    lo_o   = {sum[0], lo_i[XLEN-1:1]};
    if (is_div_i) begin
      lo_o = {lo_i[XLEN-2:0], ~borrow};
      if (borrow)
        hi_o = {hi_i[XLEN-2:0], lo_i[XLEN-1]};
      else
        hi_o = diff[XLEN-1:0];
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M-style multiply/divide,
// one bit per cycle, sign fix-up in a final state.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG =
    XLEN'(MOST_NEG_MAX >> (XLEN_MAX - XLEN));

  mdu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  mdu_op_e         op_q;
  logic            neg_a_q, neg_b_q;
  logic            dz_q, ovf_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic [XLEN-1:0] result_q;
  logic            div_zero_q;
  logic            done_q;

  mdu_op_e         op_in;
  logic            a_sgn, b_sgn;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            dz_in, ovf_in;
  logic            accept;

  logic [XLEN-1:0] hi_n, lo_n;

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;
  logic [XLEN-1:0]   fix_res;

  assign op_in  = mdu_op_e'(bus.op);
  assign accept = bus.start &&
                  (state_q == S_IDLE);

  // Operand signedness, magnitudes and the
  // special divide cases seen at accept time.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (op_in)
      OP_MULH:        begin a_sgn = 1'b1; b_sgn = 1'b1; end
      OP_MULHSU:      a_sgn = 1'b1;
      OP_DIV, OP_REM: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      default:        ;
    endcase
    neg_a  = a_sgn && bus.src_a[XLEN-1];
    neg_b  = b_sgn && bus.src_b[XLEN-1];
    mag_a  = neg_a ? -bus.src_a : bus.src_a;
    mag_b  = neg_b ? -bus.src_b : bus.src_b;
    dz_in  = op_is_div(op_in) &&
             (bus.src_b == '0);
    ovf_in = op_is_div(op_in) && a_sgn &&
             (bus.src_a == MOST_NEG) &&
             (bus.src_b == '1);
  end

  mdu_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_is_div(op_q)),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .b_i      (b_q),
    .hi_o     (hi_n),
    .lo_o     (lo_n)
  );

  // Next-state and iteration counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (FAST_ZERO && (dz_in || ovf_in))
            state_d = S_FIX;
          else
            state_d = S_CALC;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST)
          state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sign fix-up and special-case overrides.
  always_comb begin
    prod    = {hi_q, lo_q};
    prod_s  = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quot_s  = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    rem_s   = neg_a_q ? -hi_q : hi_q;
    fix_res = '0;
    unique case (op_q)
      OP_MUL:
        fix_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:
        fix_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:
        fix_res = dz_q  ? '1 :
                  ovf_q ? MOST_NEG : quot_s;
      OP_REM, OP_REMU:
        fix_res = dz_q  ? a_q :
                  ovf_q ? '0 : rem_s;
      default: fix_res = '0;
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand capture, iteration and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_MUL;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= op_in;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            dz_q    <= dz_in;
            ovf_q   <= ovf_in;
            a_q     <= bus.src_a;
            b_q     <= mag_b;
            hi_q    <= '0;
            lo_q    <= mag_a;
          end
        end
        S_CALC: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
        end
        S_FIX: begin
          result_q   <= fix_res;
          div_zero_q <= dz_q;
          done_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, setting the operand and result width (legal values 8..64, even).
REQ-002 The block SHALL have parameter FAST_ZERO, default 1; when 1, the special-case divides in REQ-016 SHALL bypass iteration.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port start  input  1  request strobe, sampled on a rising clk edge.
REQ-006 Port op  input  3  operation, using the RV32M funct3 code in mdu_pkg: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port src_a  input  XLEN  multiplicand or dividend.
REQ-008 Port src_b  input  XLEN  multiplier or divisor.
REQ-009 Port busy  output  1  high while an operation is in flight.
REQ-010 Port done  output  1  one-cycle pulse marking result valid.
REQ-011 Port result  output  XLEN  operation result, held stable until the next accepted start.
REQ-012 Port div_zero  output  1  set with done when a DIV/DIVU/REM/REMU had src_b==0; held with result.

Function
REQ-013 The block SHALL accept start only when busy==0; it SHALL ignore start while busy==1, and op/src_a/src_b SHALL be captured on the accepting edge only.
REQ-014 The block SHALL be an FSM with states IDLE, CALC and FIX: IDLE->CALC on an accepted start; CALC->FIX after exactly XLEN iterations; FIX->IDLE after one cycle; busy==1 in CALC and FIX.
REQ-015 The block SHALL assert done for exactly one cycle, in the cycle after FIX, i.e. XLEN+2 edges after the accepting edge; it SHALL update result and div_zero on the same edge.
REQ-016 With FAST_ZERO=1, the block SHALL take IDLE->FIX directly for divisor zero or signed overflow (src_a==most-negative, src_b==-1, DIV/REM), so done follows 2 edges after acceptance.
REQ-017 A start accepted in the same cycle done is high SHALL be legal, since busy is already 0 there.
REQ-018 Multiply SHALL be iterative shift-add on operand magnitudes over XLEN cycles into a 2*XLEN product; FIX SHALL apply the sign; MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN]; MULHSU treats src_a as signed and src_b as unsigned.
REQ-019 Divide SHALL be restoring radix-2 on magnitudes, one quotient bit per CALC cycle; FIX SHALL apply the signs: quotient negative iff operand signs differ, remainder takes the dividend's sign.
REQ-020 Divide by zero SHALL give quotient all-ones (DIV and DIVU) and remainder = src_a (REM and REMU), with div_zero=1.
REQ-021 Signed overflow SHALL give DIV = most-negative value and REM = 0, with div_zero=0.
REQ-022 All arithmetic SHALL be width-exact with no truncation before FIX; negation of the most-negative value SHALL wrap modulo 2^XLEN.

Reset
REQ-023 Asserting rst SHALL immediately force state IDLE, busy=0, done=0, result=0, div_zero=0 and clear internal iteration state.
REQ-024 rst asserted mid-operation SHALL abort it with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-025 mdu_pkg SHALL hold the op enum (funct3 values), the FSM state enum and helper constants such as the most-negative value.
REQ-026 The one-bit divide/multiply iteration SHALL be a combinational sub-module mdu_step, instanced once in mdu_seq, which holds the FSM, counter and registers.

Verification
REQ-027 MULH, src_a=0xFFFFFFFE, src_b=3 -> done at edge 34 after acceptance, result=0xFFFFFFFF; MUL on the same operands -> 0xFFFFFFFA.
REQ-028 DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
REQ-029 DIVU 5/0 -> 0xFFFFFFFF with div_zero=1 at edge 2; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000 with div_zero=0; REM on the same operands -> 0.
REQ-030 start held high for 40 cycles with MULHU 0xFFFFFFFF*0xFFFFFFFF -> only the first start accepted, one done pulse, result 0xFFFFFFFE; the next start is accepted on the done cycle.
REQ-031 rst pulsed at CALC iteration 10 -> busy, done and result go to 0 asynchronously, no done follows, and a subsequent MUL 6*7 -> 42.
REQ-032 XLEN=16 build, MULHSU 0x8000*0xFFFF -> 0x8000, done at edge 18.
